// File: rtl/enigma_key_driver.sv
// enigma_key_driver
//   Turns a stream of letter indices (A=0..Z=25) into isolated one-hot key pulses for the
//   rotor/reflector core, samples the core's lamp word and returns the lit letter index.
//   The core steps its first rotor on any asserted key bit. Each letter therefore produces
//   exactly one key pulse, and consecutive pulses are separated by all-zero gap cycles.
//
// Parameters
//   DRIVE_CYCLES  cycles the key is held before the lamp word is sampled (>= 1)
//   GAP_CYCLES    all-zero cycles after key release before the result is offered (>= 1)
//
// Ports
//   clk          clock, rising edge
//   resetn       asynchronous active-low reset
//   in_valid     letter offered
//   in_ready     block can accept a letter (registered, high only in idle)
//   in_letter    letter index; 26..31 are accepted and discarded
//   key_onehot   to core input, bit n = key n pressed
//   lamp_onehot  from core output
//   out_valid    encoded result available
//   out_ready    consumer takes result
//   out_letter   index of lowest set lamp bit, 31 if none set
//   err          lamp word was not exactly one-hot
//
// Configuration
//   ONEHOT_CHECK_EN  when defined, err flags a non-one-hot lamp capture; otherwise err is 0.

module enigma_key_driver #(
  parameter int unsigned DRIVE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_letter,
  output logic [25:0] key_onehot,
  input  logic [25:0] lamp_onehot,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_letter,
  output logic        err
);

  localparam int unsigned CntMax = (DRIVE_CYCLES > GAP_CYCLES) ? DRIVE_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] DriveLoad = CntW'(DRIVE_CYCLES - 1);
  localparam logic [CntW-1:0] GapLoad   = CntW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StDrive, StRelease, StOut} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            cnt_done;
  logic            accept;
  logic            letter_ok;
  logic            capture;
  logic [4:0]      lamp_enc;

  logic            in_ready_d;
  logic [25:0]     key_d;
  logic            out_valid_d;
  logic [4:0]      out_letter_d;

  // in_ready is registered and only ever high in idle, so accept implies idle.
  assign accept    = in_valid & in_ready;
  assign letter_ok = (in_letter <= 5'd25);
  assign cnt_done  = (cnt_q == '0);
  // The last drive cycle is the one whose closing edge samples the lamp word.
  assign capture   = (state_q == StDrive) && cnt_done;

  // Lowest set lamp bit wins; an all-zero word encodes as 31.
  always_comb begin
    lamp_enc = 5'd31;
    for (int i = 25; i >= 0; i--) begin
      if (lamp_onehot[i]) lamp_enc = 5'(i);
    end
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; the counter is reloaded on every state entry and counts down to zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        // Out-of-range letters are consumed without leaving idle.
        if (accept && letter_ok) begin
          state_d = StDrive;
          cnt_d   = DriveLoad;
        end
      end
      StDrive: begin
        if (cnt_done) begin
          state_d = StRelease;
          cnt_d   = GapLoad;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StRelease: begin
        if (cnt_done) begin
          state_d = StOut;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StOut: begin
        if (out_valid && out_ready) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Next values of the registered outputs, derived from the upcoming state.
  always_comb begin
    in_ready_d   = (state_d == StIdle);
    out_valid_d  = (state_d == StOut);
    out_letter_d = capture ? lamp_enc : out_letter;
    key_d        = '0;
    if (state_q == StIdle && state_d == StDrive) begin
      key_d = 26'd1 << in_letter;
    end else if (state_q == StDrive && state_d == StDrive) begin
      key_d = key_onehot;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      in_ready   <= 1'b0;
      key_onehot <= '0;
      out_valid  <= 1'b0;
      out_letter <= '0;
    end else begin
      in_ready   <= in_ready_d;
      key_onehot <= key_d;
      out_valid  <= out_valid_d;
      out_letter <= out_letter_d;
    end
  end

`ifdef ONEHOT_CHECK_EN
  logic lamp_is_onehot;
  logic err_q, err_d;

  // Exactly one bit set: non-zero, and clearing the lowest set bit leaves zero.
  assign lamp_is_onehot = (lamp_onehot != '0) &&
                          ((lamp_onehot & (lamp_onehot - 26'd1)) == '0);

  always_comb begin
    err_d = capture ? ~lamp_is_onehot : err_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
